// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing/pattern generator: pattern modes,
// colour-bar palette and default 640x480@60 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with registered sync, data-enable,
// coordinates and frame-start pulse. Counter state is also exported for pattern logic.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          active,
  output logic          line_end,
  output logic          frame_end
);

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST_C = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);

  logic [CW-1:0] h_cnt_r, v_cnt_r, x_r, y_r;
  logic          hsync_r, vsync_r, de_r, fs_r;
  logic          hs_win_s, vs_win_s, active_s, line_end_s, frame_end_s;

  assign active_s    = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
  assign hs_win_s    = (h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C);
  assign vs_win_s    = (v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C);
  assign line_end_s  = (h_cnt_r == H_LAST_C);
  assign frame_end_s = line_end_s && (v_cnt_r == V_LAST_C);

  // Raster position: h wraps every line, v advances on the h wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (line_end_s) begin
      h_cnt_r <= '0;
      v_cnt_r <= (v_cnt_r == V_LAST_C) ? '0 : v_cnt_r + CW'(1);
    end else begin
      h_cnt_r <= h_cnt_r + CW'(1);
    end
  end

  // Output registers: one clock behind the counter state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_r <= ~HS_ON;
      vsync_r <= ~VS_ON;
      de_r    <= 1'b0;
      fs_r    <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
    end else begin
      hsync_r <= hs_win_s ? HS_ON : ~HS_ON;
      vsync_r <= vs_win_s ? VS_ON : ~VS_ON;
      de_r    <= active_s;
      fs_r    <= (h_cnt_r == '0) && (v_cnt_r == '0);
      if (active_s) begin
        x_r <= h_cnt_r;
        y_r <= v_cnt_r;
      end
    end
  end

  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign frame_start = fs_r;
  assign x           = x_r;
  assign y           = y_r;
  assign h_cnt       = h_cnt_r;
  assign v_cnt       = v_cnt_r;
  assign active      = active_s;
  assign line_end    = line_end_s;
  assign frame_end   = frame_end_s;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus RGB565 test-pattern generator (solid, bars, checker, gradient).
// Mode and colour are latched only at frame end so a frame is never split.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CHECK_LOG2 = 5,
  parameter int CW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [15:0]   solid_color,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [15:0]   rgb,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start
);

  localparam logic [CW-1:0] BAR_LAST_C  = CW'(H_ACTIVE / 8 - 1);
  localparam logic [CW-1:0] GRAD_LAST_C = CW'(H_ACTIVE / 64 - 1);

  logic [CW-1:0] h_cnt_s, v_cnt_s;
  logic          active_s, line_end_s, frame_end_s, unused_cnt_s;
  mode_e         mode_q_r;
  logic [15:0]   color_q_r, pix_s, rgb_r;
  logic [CW-1:0] bar_cnt_r, grad_cnt_r;
  logic [2:0]    bar_idx_r;
  logic [5:0]    grad_r;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .CW(CW)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frame_start(frame_start),
    .x          (x),
    .y          (y),
    .h_cnt      (h_cnt_s),
    .v_cnt      (v_cnt_s),
    .active     (active_s),
    .line_end   (line_end_s),
    .frame_end  (frame_end_s)
  );

  assign unused_cnt_s = ^{h_cnt_s, v_cnt_s};

  // Pattern selection is captured on the last cycle of each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q_r  <= MODE_SOLID;
      color_q_r <= 16'h0000;
    end else if (frame_end_s) begin
      mode_q_r  <= mode_e'(mode);
      color_q_r <= solid_color;
    end
  end

  // Bar and gradient steppers track the current column without a divider
  always_ff @(posedge clk) begin
    if (rst || line_end_s) begin
      bar_cnt_r  <= '0;
      bar_idx_r  <= 3'd0;
      grad_cnt_r <= '0;
      grad_r     <= 6'd0;
    end else if (active_s) begin
      if (bar_cnt_r == BAR_LAST_C) begin
        bar_cnt_r <= '0;
        bar_idx_r <= (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
      end else begin
        bar_cnt_r <= bar_cnt_r + CW'(1);
      end
      if (grad_cnt_r == GRAD_LAST_C) begin
        grad_cnt_r <= '0;
        grad_r     <= (grad_r == 6'd63) ? 6'd63 : grad_r + 6'd1;
      end else begin
        grad_cnt_r <= grad_cnt_r + CW'(1);
      end
    end
  end

  // Pixel colour for the current raster position
  always_comb begin
    pix_s = 16'h0000;
    if (active_s) begin
      case (mode_q_r)
        MODE_SOLID: pix_s = color_q_r;
        MODE_BARS:  pix_s = bar_color(bar_idx_r);
        MODE_CHECK: pix_s = (h_cnt_s[CHECK_LOG2] ^ v_cnt_s[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
        MODE_GRAD:  pix_s = {grad_r[5:1], grad_r, grad_r[5:1]};
        default:    pix_s = 16'h0000;
      endcase
    end else begin
      pix_s = 16'h0000;
    end
  end

  // RGB output register, aligned with the timing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 16'h0000;
    end else begin
      rgb_r <= pix_s;
    end
  end

  assign rgb = rgb_r;

endmodule
